// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Measures the bit period of a 0x55 ('U') sync character (8N1, LSB first)
//   on the raw RX line. It reports the result as a clock-cycles-per-bit
//   divider for loading into the UART clk_divider register.
//
//   Ports
//     clk_i      system clock
//     rst_i      synchronous active-high reset
//     uart_rx_i  raw asynchronous RX line, idle high
//     start_i    one-cycle arm request, honoured only when idle
//     busy_o     high while armed or measuring
//     divider_o  last successfully measured cycles-per-bit
//     done_o     one-cycle pulse when divider_o updates
//     locked_o   high after a success, cleared by start_i or reset
//     err_o      one-cycle pulse on a failed measurement
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | waiting for start_i
//   WAIT_HIGH   | armed, waiting for the line to be seen idle-high
//   WAIT_START  | waiting for the start-bit falling edge
//   MEASURE     | timing falling-edge intervals (start, d1, d3, d5, d7)
//   STOP_EDGE   | waiting for the end of d7 (rising edge), with a timeout
//   STOP_HOLD   | line must stay high for one estimated bit (stop bit)
//   DONE        | range-check the estimate, publish or flag error
module uart_autobaud #(
  parameter int DIVIDER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_DIVIDER   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     uart_rx_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic [DIVIDER_WIDTH-1:0] divider_o,
  output logic                     done_o,
  output logic                     locked_o,
  output logic                     err_o
);

  localparam int DW = DIVIDER_WIDTH;
  localparam int TW = DIVIDER_WIDTH + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HIGH,
    ST_WAIT_START,
    ST_MEASURE,
    ST_STOP_EDGE,
    ST_STOP_HOLD,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          ref_q, ref_d;
  logic [DW-1:0]          timer_q, timer_d;
  logic [DW-1:0]          divider_q, divider_d;
  logic [1:0]             edge_idx_q, edge_idx_d;
  logic [TW-1:0]          total_q, total_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;

  logic          rx_s;
  logic          fall;
  logic          rise;
  logic          fail;
  logic [DW-1:0] interval;
  logic [DW-1:0] delta;
  logic [DW-1:0] tol;
  logic [TW-1:0] total_sum;
  logic [DW-1:0] est_cur;
  logic [DW-1:0] est_new;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;
  assign rise = ~rx_prev_q & rx_s;

  // cnt is cleared on the edge cycle, so cnt+1 is the full edge-to-edge spacing.
  assign interval  = cnt_q + DW'(1);
  assign delta     = (interval >= ref_q) ? (interval - ref_q) : (ref_q - interval);
  assign tol       = ref_q >> 3;
  assign total_sum = total_q + TW'(interval);

  // (total + 4) >> 3 rewritten as (total >> 3) + total[2]; the result never
  // exceeds half of the DW range because each interval is below 2^DW.
  assign est_cur = total_q[TW-1:3] + DW'(total_q[2]);
  assign est_new = total_sum[TW-1:3] + DW'(total_sum[2]);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    rx_prev_d  = rx_s;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    timer_d    = timer_q;
    divider_d  = divider_q;
    edge_idx_d = edge_idx_q;
    total_d    = total_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_WAIT_HIGH;
          busy_d   = 1'b1;
          locked_d = 1'b0;
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        if (fall) begin
          state_d    = ST_MEASURE;
          cnt_d      = '0;
          edge_idx_d = '0;
          total_d    = '0;
        end
      end

      ST_MEASURE: begin
        if (cnt_q == '1) begin
          fail = 1'b1;
        end else if (fall) begin
          if ((edge_idx_q != 2'd0) && (delta > tol)) begin
            fail = 1'b1;
          end else begin
            cnt_d      = '0;
            total_d    = total_sum;
            edge_idx_d = edge_idx_q + 2'd1;
            if (edge_idx_q == 2'd0) ref_d = interval;
            if (edge_idx_q == 2'd3) begin
              // Four intervals span eight bit periods (start through d6).
              state_d = ST_STOP_EDGE;
              timer_d = est_new + (est_new >> 1);
            end
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      ST_STOP_EDGE: begin
        if (rise) begin
          state_d = ST_STOP_HOLD;
          timer_d = (est_cur == '0) ? '0 : (est_cur - DW'(1));
        end else if (timer_q == '0) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end

      ST_STOP_HOLD: begin
        if (!rx_s) begin
          fail = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (est_cur < DW'(MIN_DIVIDER)) begin
          err_d = 1'b1;
        end else begin
          divider_d = est_cur;
          done_d    = 1'b1;
          locked_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (fail) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      ref_q      <= '0;
      timer_q    <= '0;
      divider_q  <= '0;
      edge_idx_q <= '0;
      total_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      timer_q    <= timer_d;
      divider_q  <= divider_d;
      edge_idx_q <= edge_idx_d;
      total_q    <= total_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign busy_o    = busy_q;
  assign divider_o = divider_q;
  assign done_o    = done_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: directed frames with known outcomes plus random
// frames whose outcome comes from a waveform-level reference model.
module tb_uart_autobaud;

  localparam int DW      = 32;
  localparam int MIN_DIV = 4;

  localparam int K_PENDING = 0;
  localparam int K_DONE    = 1;
  localparam int K_ERR     = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          start;
  logic          busy;
  logic [DW-1:0] divider;
  logic          done;
  logic          locked;
  logic          err;

  always #5 clk = ~clk;

  uart_autobaud #(
    .DIVIDER_WIDTH(DW),
    .SYNC_STAGES  (2),
    .MIN_DIVIDER  (MIN_DIV)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .uart_rx_i(rx),
    .start_i  (start),
    .busy_o   (busy),
    .divider_o(divider),
    .done_o   (done),
    .locked_o (locked),
    .err_o    (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done_pulses = 0;
  int n_err_pulses  = 0;

  longint exp_div    = 0;
  bit     exp_locked = 1'b0;

  int seg_lvl[$];
  int seg_dur[$];

  always @(negedge clk) begin
    if (done === 1'b1) n_done_pulses++;
    if (err === 1'b1) n_err_pulses++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame of 10 bits (start, 8 data LSB first, stop) followed by idle high.
  // Jitter moves every bit boundary except the start edge and the d7 edge.
  task automatic build_frame(input logic [7:0] b, input int t_bit, input int jit, input bit stop_low);
    int bnd[11];
    int lvl;
    seg_lvl.delete();
    seg_dur.delete();
    for (int i = 0; i <= 10; i++) begin
      bnd[i] = i * t_bit;
      if (jit > 0 && i != 0 && i != 8 && i != 10)
        bnd[i] += int'($urandom_range(2 * jit, 0)) - jit;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) lvl = 0;
      else if (i == 9) lvl = stop_low ? 0 : 1;
      else lvl = int'(b[i-1]);
      seg_lvl.push_back(lvl);
      seg_dur.push_back(bnd[i+1] - bnd[i]);
    end
    seg_lvl.push_back(1);
    seg_dur.push_back(4 * t_bit + 40);
  endtask

  // Outcome predicted from line transition times only.
  task automatic model(output int kind, output longint est);
    longint falls[$];
    longint rises[$];
    longint t, iv, ref_iv, total, dev, lim, r, entry;
    int prev;
    bit found;
    t = 0; prev = 1; ref_iv = 0; total = 0; r = 0;
    kind = K_PENDING;
    est = 0;
    foreach (seg_lvl[i]) begin
      if (prev == 1 && seg_lvl[i] == 0) falls.push_back(t);
      if (prev == 0 && seg_lvl[i] == 1) rises.push_back(t);
      prev = seg_lvl[i];
      t += seg_dur[i];
    end
    for (int k = 1; k <= 4; k++) begin
      if (k >= falls.size()) return;
      iv = falls[k] - falls[k-1];
      if (k == 1) ref_iv = iv;
      else begin
        dev = (iv > ref_iv) ? iv - ref_iv : ref_iv - iv;
        if (dev > (ref_iv >> 3)) begin
          kind = K_ERR;
          return;
        end
      end
      total += iv;
    end
    est = (total + 4) >> 3;
    lim = est + (est >> 1);
    entry = falls[4] + 1;
    found = 1'b0;
    foreach (rises[i]) if (!found && rises[i] > falls[4]) begin
      r = rises[i];
      found = 1'b1;
    end
    if (!found) return;
    if (r - entry > lim) begin
      kind = K_ERR;
      return;
    end
    foreach (falls[i]) if (falls[i] > r && falls[i] <= r + est) begin
      kind = K_ERR;
      return;
    end
    kind = (est < MIN_DIV) ? K_ERR : K_DONE;
  endtask

  task automatic drive_segments();
    foreach (seg_lvl[i]) begin
      rx = seg_lvl[i][0];
      repeat (seg_dur[i]) @(negedge clk);
    end
  endtask

  task automatic pulse_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_locked = 1'b0;
    check_val({name, " busy_armed"}, 64'(busy), 64'd1);
    check_val({name, " locked_cleared"}, 64'(locked), 64'd0);
    check_val({name, " div_held"}, 64'(divider), 64'(exp_div));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_div = 0;
    exp_locked = 1'b0;
  endtask

  task automatic run_frame(input string name, input int kind, input longint est);
    int d0, e0;
    d0 = n_done_pulses;
    e0 = n_err_pulses;
    pulse_start(name);
    repeat (5) @(negedge clk);
    drive_segments();
    repeat (10) @(negedge clk);
    if (kind == K_DONE) begin
      exp_div = est;
      exp_locked = 1'b1;
    end
    check_val({name, " done_pulses"}, 64'(n_done_pulses - d0), (kind == K_DONE) ? 64'd1 : 64'd0);
    check_val({name, " err_pulses"}, 64'(n_err_pulses - e0), (kind == K_ERR) ? 64'd1 : 64'd0);
    check_val({name, " divider"}, 64'(divider), 64'(exp_div));
    check_val({name, " locked"}, 64'(locked), 64'(exp_locked));
    check_val({name, " busy"}, 64'(busy), (kind == K_PENDING) ? 64'd1 : 64'd0);
    if (kind == K_PENDING) begin
      apply_reset();
      check_val({name, " busy_after_reset"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int d0, e0, kind;
    longint est;
    logic [7:0] b;
    int t_bit, sel, jit;

    rst = 1'b1;
    rx = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst busy", 64'(busy), 64'd0);
    check_val("rst divider", 64'(divider), 64'd0);
    check_val("rst done", 64'(done), 64'd0);
    check_val("rst locked", 64'(locked), 64'd0);
    check_val("rst err", 64'(err), 64'd0);

    build_frame(8'h55, 100, 0, 1'b0);
    run_frame("u100", K_DONE, 100);

    build_frame(8'h55, 100, 3, 1'b0);
    run_frame("u100_jitter", K_DONE, 100);

    build_frame(8'h55, 868, 0, 1'b0);
    run_frame("u868", K_DONE, 868);

    build_frame(8'h57, 100, 0, 1'b0);
    run_frame("byte57", K_ERR, 0);

    build_frame(8'h55, 100, 0, 1'b1);
    run_frame("stop_low", K_ERR, 0);

    build_frame(8'h55, 2, 0, 1'b0);
    run_frame("too_fast", K_ERR, 0);

    // Reset lands just after the third falling edge reaches the synchroniser.
    build_frame(8'h55, 100, 0, 1'b0);
    d0 = n_done_pulses;
    e0 = n_err_pulses;
    pulse_start("midrst");
    repeat (5) @(negedge clk);
    fork
      drive_segments();
      begin
        repeat (4 * 100 + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_div = 0;
        exp_locked = 1'b0;
        check_val("midrst busy", 64'(busy), 64'd0);
        check_val("midrst divider", 64'(divider), 64'd0);
        check_val("midrst done", 64'(done), 64'd0);
        check_val("midrst locked", 64'(locked), 64'd0);
        check_val("midrst err", 64'(err), 64'd0);
      end
    join
    repeat (10) @(negedge clk);
    check_val("midrst no_done", 64'(n_done_pulses - d0), 64'd0);
    check_val("midrst no_err", 64'(n_err_pulses - e0), 64'd0);

    build_frame(8'h55, 50, 0, 1'b0);
    run_frame("u50_after_rst", K_DONE, 50);

    for (int n = 0; n < 6; n++) begin
      t_bit = int'($urandom_range(40, 5));
      sel = int'($urandom_range(2, 0));
      b = (sel == 1) ? 8'($urandom) : 8'h55;
      jit = (sel == 0) ? 1 : 0;
      build_frame(b, t_bit, jit, 1'b0);
      model(kind, est);
      run_frame($sformatf("rand%0d_b%02h_t%0d", n, b, t_bit), kind, est);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
